vga_sync_gen: RTL and testbench

//   640x480@60Hz VGA timing generator: upstream feeder of the text/image overlay stages.

---
 rtl/vga_sync_gen_if.sv | 18 +
 rtl/vga_sync_gen.sv | 107 ++++++++++
 tb/tb_vga_sync_gen.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/vga_sync_gen_if.sv
// VGA timing bundle: pixel strobe, pixel coordinates and sync/blanking outputs.
interface vga_sync_gen_if;
    logic       p_tick;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic       video_on;
    logic       hsync;
    logic       vsync;
    logic       frame_start;

    modport master (
        output p_tick, pixel_x, pixel_y, video_on, hsync, vsync, frame_start
    );

    modport slave (
        input  p_tick, pixel_x, pixel_y, video_on, hsync, vsync, frame_start
    );
endinterface

// File: rtl/vga_sync_gen.sv
// 640x480@60Hz VGA timing generator; free-running, no backpressure. Outputs registered with 0 clk skew
// to pixel_x/pixel_y; defining VGA_SYNC_DELAY_EN delays hsync/vsync/video_on by SYNC_DELAY clks.
module vga_sync_gen #(
    parameter int H_DISPLAY  = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_DISPLAY  = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter int TICK_DIV   = 4
`ifdef VGA_SYNC_DELAY_EN
    , parameter int SYNC_DELAY = 2
`endif
) (
    input  logic           clk,
    input  logic           reset,
    vga_sync_gen_if.master vga
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = $clog2(TICK_DIV);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
    localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
    localparam logic [9:0] HS_FIRST = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HS_LAST  = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] VS_LAST  = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic [DIV_W-1:0] div_cnt, div_next;
    logic [9:0]       x_cnt, y_cnt, x_next, y_next;
    logic             tick, line_end;
    logic             p_tick_r, hsync_r, vsync_r, video_on_r, frame_start_r;

    always_comb begin
        tick     = (div_cnt == DIV_LAST);
        line_end = tick && (x_cnt == H_LAST);
        div_next = tick ? '0 : div_cnt + DIV_W'(1);
        x_next   = x_cnt;
        y_next   = y_cnt;
        if (tick) begin
            x_next = line_end ? '0 : x_cnt + 10'd1;
        end
        if (line_end) begin
            y_next = (y_cnt == V_LAST) ? '0 : y_cnt + 10'd1;
        end
    end

    // Flags decode the next-state counters so they land on the same edge as pixel_x/pixel_y.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt       <= '0;
            x_cnt         <= '0;
            y_cnt         <= '0;
            p_tick_r      <= 1'b0;
            hsync_r       <= 1'b1;
            vsync_r       <= 1'b1;
            video_on_r    <= 1'b0;
            frame_start_r <= 1'b0;
        end else begin
            div_cnt       <= div_next;
            x_cnt         <= x_next;
            y_cnt         <= y_next;
            p_tick_r      <= (div_next == DIV_LAST);
            hsync_r       <= !((x_next >= HS_FIRST) && (x_next <= HS_LAST));
            vsync_r       <= !((y_next >= VS_FIRST) && (y_next <= VS_LAST));
            video_on_r    <= (x_next < H_VIS) && (y_next < V_VIS);
            frame_start_r <= line_end && (y_cnt == V_LAST);
        end
    end

    assign vga.p_tick      = p_tick_r;
    assign vga.pixel_x     = x_cnt;
    assign vga.pixel_y     = y_cnt;
    assign vga.frame_start = frame_start_r;

`ifdef VGA_SYNC_DELAY_EN
    logic [SYNC_DELAY-1:0] hs_sr, vs_sr, vo_sr;

    always_ff @(posedge clk) begin
        if (reset) begin
            hs_sr <= '1;
            vs_sr <= '1;
            vo_sr <= '0;
        end else begin
            hs_sr <= SYNC_DELAY'({hs_sr, hsync_r});
            vs_sr <= SYNC_DELAY'({vs_sr, vsync_r});
            vo_sr <= SYNC_DELAY'({vo_sr, video_on_r});
        end
    end

    assign vga.hsync    = hs_sr[SYNC_DELAY-1];
    assign vga.vsync    = vs_sr[SYNC_DELAY-1];
    assign vga.video_on = vo_sr[SYNC_DELAY-1];
`else
    assign vga.hsync    = hsync_r;
    assign vga.vsync    = vsync_r;
    assign vga.video_on = video_on_r;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench: full-size timing for reset/tick/line checks, a shrunken instance for frame-level checks.
module tb_vga_sync_gen;

`ifdef VGA_SYNC_DELAY_EN
    localparam int SD = 2;
`else
    localparam int SD = 0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    vga_sync_gen_if big_if ();
    vga_sync_gen_if sm_if ();

    vga_sync_gen u_big (
        .clk   (clk),
        .reset (reset),
        .vga   (big_if)
    );

    // Small frame: H_TOTAL 15 (hsync low x=10..12), V_TOTAL 11 (vsync low y=8..9), 2 clks/pixel, 330 clks/frame.
    vga_sync_gen #(
        .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_DISPLAY(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(1),
        .TICK_DIV(2)
    ) u_sm (
        .clk   (clk),
        .reset (reset),
        .vga   (sm_if)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    initial begin
        int big_hs_low  = 0;
        int big_hs_fall = -1;
        int big_vo_zero = -1;
        int big_y1      = -1;
        int big_fs      = 0;
        int sm_fs       = 0;
        int sm_fs_first = -1;
        int sm_vo       = 0;
        int sm_hs       = 0;
        int sm_vs       = 0;
        int sm_vs_fall  = -1;
        int waited      = 0;

        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rst_ptick",  big_if.p_tick,      0);
        check("rst_x",      big_if.pixel_x,     0);
        check("rst_y",      big_if.pixel_y,     0);
        check("rst_vo",     big_if.video_on,    0);
        check("rst_hs",     big_if.hsync,       1);
        check("rst_vs",     big_if.vsync,       1);
        check("rst_fs",     big_if.frame_start, 0);
        reset = 1'b0;

        // k counts rising edges since release; sampling happens on the following falling edge.
        for (int k = 1; k <= 3300; k++) begin
            @(negedge clk);
            if (k <= 12) begin
                check($sformatf("ptick_k%0d", k), big_if.p_tick, int'(k % 4 == 3));
                check($sformatf("x_k%0d", k), big_if.pixel_x, k / 4);
            end
            if (k == SD + 1) begin
                check("first_vo", big_if.video_on, 1);
                check("first_hs", big_if.hsync, 1);
                check("first_vs", big_if.vsync, 1);
            end
            if (k == 2624) check("x_656", big_if.pixel_x, 656);
            if (k == 3199) check("x_799", big_if.pixel_x, 799);
            if (k == 3200) check("x_wrap", big_if.pixel_x, 0);
            if (!big_if.hsync) begin
                big_hs_low++;
                if (big_hs_fall < 0) big_hs_fall = k;
            end
            if (!big_if.video_on && k > SD && big_vo_zero < 0) big_vo_zero = k;
            if (big_if.pixel_y == 10'd1 && big_y1 < 0) big_y1 = k;
            if (big_if.frame_start) big_fs++;

            if (k <= 700 && sm_if.frame_start) begin
                sm_fs++;
                if (sm_fs_first < 0) sm_fs_first = k;
            end
            if (k >= 330 + SD && k <= 659 + SD) begin
                if (sm_if.video_on) sm_vo++;
                if (!sm_if.hsync) sm_hs++;
                if (!sm_if.vsync) begin
                    sm_vs++;
                    if (sm_vs_fall < 0) sm_vs_fall = k;
                end
            end
            if (k == 345 + SD) check("sm_vo_x7",  sm_if.video_on, 1);
            if (k == 346 + SD) check("sm_vo_x8",  sm_if.video_on, 0);
            if (k == 510 + SD) check("sm_vo_y6",  sm_if.video_on, 0);
        end

        check("line_hs_low",   big_hs_low,  384);
        check("line_hs_fall",  big_hs_fall, 2624 + SD);
        check("line_vo_off",   big_vo_zero, 2560 + SD);
        check("line_y_inc",    big_y1,      3200);
        check("line_no_fs",    big_fs,      0);
        check("frm_fs_count",  sm_fs,       2);
        check("frm_fs_first",  sm_fs_first, 330);
        check("frm_vo_clks",   sm_vo,       96);
        check("frm_hs_clks",   sm_hs,       66);
        check("frm_vs_clks",   sm_vs,       60);
        check("frm_vs_fall",   sm_vs_fall,  570 + SD);

        // Mid-frame reset inside the hsync pulse.
        while (!(sm_if.pixel_x == 10'd12 && sm_if.pixel_y == 10'd5) && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        check("mid_reached", int'(waited < 400), 1);
        reset = 1'b1;
        @(negedge clk);
        check("mid_x",     sm_if.pixel_x,     0);
        check("mid_y",     sm_if.pixel_y,     0);
        check("mid_hs",    sm_if.hsync,       1);
        check("mid_vs",    sm_if.vsync,       1);
        check("mid_vo",    sm_if.video_on,    0);
        check("mid_ptick", sm_if.p_tick,      0);
        check("mid_fs",    sm_if.frame_start, 0);
        check("mid_big_x", big_if.pixel_x,    0);
        reset = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            check($sformatf("re_ptick_k%0d", k), sm_if.p_tick, int'(k % 2 == 1));
            check($sformatf("re_x_k%0d", k), sm_if.pixel_x, k / 2);
            if (k == SD + 1) check("re_vo", sm_if.video_on, 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
